// File: rtl/tron_pkg.sv
// Shared definitions for the Tron input path and the downstream game/render
// stage: direction encodings, button indices and the debounce default.
package tron_pkg;

    // 10 ms at 100 MHz
    localparam int DB_COUNT_DEF = 1_000_000;
    localparam int DB_CNT_W     = 20;

    // Bit order of the debounced button vector {C,U,D,L,R}
    localparam int NUM_BTN = 5;
    localparam int BTN_R   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_C   = 4;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-level debounce counter and a
// registered one-cycle pulse on each 0->1 change of the stable level.
//   clk, reset_n : system clock, async active-low reset
//   btn_raw      : raw asynchronous button
//   level        : debounced stable level
//   pulse        : one-cycle press pulse
module btn_debounce
    import tron_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_COUNT - 1);

    logic [1:0]          sync_q, sync_d;
    logic                stable_q, stable_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                prev_q, prev_d;
    logic                pulse_q, pulse_d;

    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        stable_d = stable_q;
        cnt_d    = cnt_q + 1'b1;
        if (sync_q[1] == stable_q) begin
            // Agreement (or a bounce back) restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end
        prev_d  = stable_q;
        pulse_d = stable_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level = stable_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/tron_input_ctrl.sv
// Player-1 input controller: debounces the five pushbuttons and turns press
// pulses into a direction that only changes on the game step strobe, plus a
// restart pulse from the centre button.
//   clk, reset_n             : system clock, async active-low reset
//   btnU/D/L/R/C             : raw asynchronous pushbuttons
//   move_tick                : single-cycle game step strobe
//   dir                      : committed direction (R=00 L=01 U=10 D=11)
//   restart                  : single-cycle game reset request
//   btn_level                : debounced levels {C,U,D,L,R}
module tron_input_ctrl
    import tron_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    input  logic       move_tick,
    output logic [1:0] dir,
    output logic       restart,
    output logic [4:0] btn_level
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    assign raw = {btnC, btnU, btnD, btnL, btnR};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_raw (raw[i]),
            .level   (btn_level[i]),
            .pulse   (press[i])
        );
    end

    dir_e dir_q, dir_d;
    dir_e pend_q, pend_d;
    dir_e cand;
    logic cand_vld;
    logic accept;
    logic restart_q, restart_d;

    // Same-cycle presses resolve U > D > L > R.
    always_comb begin
        cand_vld = 1'b1;
        cand     = DIR_RIGHT;
        if (press[BTN_U])      cand = DIR_UP;
        else if (press[BTN_D]) cand = DIR_DOWN;
        else if (press[BTN_L]) cand = DIR_LEFT;
        else if (press[BTN_R]) cand = DIR_RIGHT;
        else                   cand_vld = 1'b0;
    end

    // Reversal is judged against the committed dir, not the pending one.
    assign accept = cand_vld && !is_reverse(cand, dir_q);

    always_comb begin
        dir_d     = dir_q;
        pend_d    = pend_q;
        restart_d = 1'b0;
        if (press[BTN_C]) begin
            // Restart wins over any turn or step in the same cycle.
            dir_d     = DIR_RIGHT;
            pend_d    = DIR_RIGHT;
            restart_d = 1'b1;
        end else begin
            if (accept) pend_d = cand;
            if (move_tick) dir_d = pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            restart_q <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            restart_q <= restart_d;
        end
    end

    assign dir     = dir_q;
    assign restart = restart_q;

endmodule

// File: tb/tb_tron_input_ctrl.sv
module tb_tron_input_ctrl;

    localparam int DB   = 4;
    localparam int MAXT = 16384;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] dir;
    logic       restart;
    logic [4:0] btn_level;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tron_input_ctrl #(.DB_COUNT(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btnU      (btnU),
        .btnD      (btnD),
        .btnL      (btnL),
        .btnR      (btnR),
        .btnC      (btnC),
        .move_tick (move_tick),
        .dir       (dir),
        .restart   (restart),
        .btn_level (btn_level)
    );

    // ---------------- reference model ----------------
    // Debounce: a level is accepted once the synchronized input (raw delayed
    // two cycles, zero right after reset) has disagreed with it for DB
    // consecutive cycles. Press pulse appears one cycle after the new level.
    // Game rules: centre restarts; otherwise the highest-priority pressed
    // direction that is not a U-turn becomes pending and is committed on tick.
    int         m_t = 0;
    bit         m_samp [5][MAXT];
    bit         m_seen [5][MAXT];
    bit         m_st   [5][MAXT];
    logic [1:0] m_dir = 2'b00, m_pend = 2'b00;
    logic       m_restart = 1'b0;
    logic [4:0] m_level = 5'b0, m_pulse = 5'b0;

    function automatic bit st_at(int b, int i);
        return (i < 0) ? 1'b0 : m_st[b][i];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [4:0] raw;
        logic [1:0] cand;
        bit         has, flip, cur;
        if (!reset_n) begin
            m_t = 0; m_dir = 2'b00; m_pend = 2'b00; m_restart = 1'b0;
            m_level = 5'b0; m_pulse = 5'b0;
        end else begin
            raw = {btnC, btnU, btnD, btnL, btnR};
            if (m_pulse[4]) begin
                m_dir = 2'b00; m_pend = 2'b00; m_restart = 1'b1;
            end else begin
                m_restart = 1'b0;
                has = 1'b1;
                if (m_pulse[3])      cand = 2'b10;
                else if (m_pulse[2]) cand = 2'b11;
                else if (m_pulse[1]) cand = 2'b01;
                else if (m_pulse[0]) cand = 2'b00;
                else begin has = 1'b0; cand = 2'b00; end
                if (has && cand != (m_dir ^ 2'b01)) m_pend = cand;
                if (move_tick) m_dir = m_pend;
            end
            m_t++;
            if (m_t < MAXT) begin
                for (int b = 0; b < 5; b++) begin
                    m_samp[b][m_t-1] = raw[b];
                    m_seen[b][m_t-1] = (m_t >= 3) ? m_samp[b][m_t-3] : 1'b0;
                    cur  = m_level[b];
                    flip = (m_t >= DB);
                    for (int k = 0; k < DB; k++)
                        if (flip && m_seen[b][m_t-1-k] == cur) flip = 1'b0;
                    m_level[b]     = flip ? ~cur : cur;
                    m_st[b][m_t-1] = m_level[b];
                    m_pulse[b]     = st_at(b, m_t-2) & ~st_at(b, m_t-3);
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        {btnC, btnU, btnD, btnL, btnR} = 5'b0;
        move_tick = 1'b0;
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] exp;
        {btnC, btnU, btnD, btnL, btnR} = 5'b11111;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++;
            if ({restart, dir, btn_level} !== 8'h00) begin
                nerr++;
                $display("FAIL reset_hold: got %0h want 00", {restart, dir, btn_level});
            end
        end
        reset_n = 1'b1;
        // Buttons held through reset: levels appear only after a full debounce,
        // and the centre press restarts, overriding the direction presses.
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = {(k == 8), 2'b00, (k >= 6) ? 5'h1F : 5'h00};
            nvec++;
            if ({restart, dir, btn_level} !== exp) begin
                nerr++;
                $display("FAIL reset_release k=%0d: got %0h want %0h", k, {restart, dir, btn_level}, exp);
            end
        end
        {btnC, btnU, btnD, btnL, btnR} = 5'b0;
        cyc(10);
    endtask

    task automatic test_bounce();
        apply_reset();
        move_tick = 1'b1;
        btnU = 1'b1; cyc(2);
        btnU = 1'b0; cyc(2);
        btnU = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            nvec++;
            if (btn_level[3] !== (k >= 6) || dir !== ((k >= 8) ? 2'b10 : 2'b00)) begin
                nerr++;
                $display("FAIL bounce k=%0d: got lvl=%0b dir=%0b want lvl=%0b dir=%0b",
                         k, btn_level[3], dir, (k >= 6), (k >= 8) ? 2'b10 : 2'b00);
            end
        end
        move_tick = 1'b0;
        btnU = 1'b0;
        cyc(10);
    endtask

    task automatic test_reversal();
        apply_reset();
        btnL = 1'b1; cyc(10); btnL = 1'b0; cyc(10);
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        nvec++;
        if (dir !== 2'b00) begin
            nerr++; $display("FAIL reversal_left: got %0b want 00", dir);
        end
        btnU = 1'b1; cyc(10);
        nvec++;
        if (dir !== 2'b00) begin
            nerr++; $display("FAIL no_tick_hold: got %0b want 00", dir);
        end
        btnU = 1'b0; cyc(10);
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        nvec++;
        if (dir !== 2'b10) begin
            nerr++; $display("FAIL reversal_up: got %0b want 10", dir);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        btnU = 1'b1; btnR = 1'b1;
        cyc(7);
        nvec++;
        if (dir !== 2'b00) begin
            nerr++; $display("FAIL simul_pre: got %0b want 00", dir);
        end
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        nvec++;
        if (dir !== 2'b10) begin
            nerr++; $display("FAIL simul_tick: got %0b want 10", dir);
        end
        btnU = 1'b0; btnR = 1'b0;
        cyc(10);
    endtask

    task automatic test_overwrite();
        apply_reset();
        btnU = 1'b1; cyc(10); btnU = 1'b0; cyc(10);
        btnD = 1'b1; cyc(10); btnD = 1'b0; cyc(10);
        nvec++;
        if (dir !== 2'b00) begin
            nerr++; $display("FAIL overwrite_pre: got %0b want 00", dir);
        end
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        nvec++;
        if (dir !== 2'b11) begin
            nerr++; $display("FAIL overwrite: got %0b want 11", dir);
        end
    endtask

    task automatic test_restart();
        int rcnt;
        apply_reset();
        btnU = 1'b1; cyc(12);
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        btnU = 1'b0; cyc(10);
        nvec++;
        if (dir !== 2'b10) begin
            nerr++; $display("FAIL restart_setup: got %0b want 10", dir);
        end
        btnC = 1'b1; btnL = 1'b1;
        rcnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (restart === 1'b1) begin
                rcnt++;
                nvec++;
                if (dir !== 2'b00) begin
                    nerr++; $display("FAIL restart_dir: got %0b want 00", dir);
                end
            end
        end
        nvec++;
        if (rcnt != 1) begin
            nerr++; $display("FAIL restart_count: got %0d want 1", rcnt);
        end
        btnC = 1'b0; btnL = 1'b0; cyc(10);
        move_tick = 1'b1; cyc(1); move_tick = 1'b0;
        nvec++;
        if (dir !== 2'b00) begin
            nerr++; $display("FAIL restart_left_ignored: got %0b want 00", dir);
        end
        // New press after release gives exactly one more restart.
        btnC = 1'b1; rcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (restart === 1'b1) rcnt++;
        end
        nvec++;
        if (rcnt != 1) begin
            nerr++; $display("FAIL restart_repress: got %0d want 1", rcnt);
        end
        btnC = 1'b0; cyc(10);
    endtask

    task automatic test_midreset();
        apply_reset();
        btnR = 1'b1;
        cyc(5);
        reset_n = 1'b0;
        cyc(1);
        nvec++;
        if (btn_level !== 5'b0) begin
            nerr++; $display("FAIL midreset_level: got %0h want 00", btn_level);
        end
        cyc(1);
        reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            nvec++;
            if (btn_level[0] !== (k >= 6)) begin
                nerr++;
                $display("FAIL midreset k=%0d: got %0b want %0b", k, btn_level[0], (k >= 6));
            end
        end
        btnR = 1'b0; cyc(10);
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            got = {restart, dir, btn_level};
            exp = {m_restart, m_dir, m_level};
            nvec++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL random cyc=%0d: got %0h want %0h", k, got, exp);
            end
            if ($urandom_range(9) == 0) btnU = ~btnU;
            if ($urandom_range(9) == 0) btnD = ~btnD;
            if ($urandom_range(9) == 0) btnL = ~btnL;
            if ($urandom_range(9) == 0) btnR = ~btnR;
            if ($urandom_range(59) == 0) btnC = ~btnC;
            move_tick = ($urandom_range(5) == 0);
        end
        move_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_reversal();
        test_simultaneous();
        test_overwrite();
        test_restart();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
